// File: rtl/controle_ula_aoc.sv
// Instruction controller driving an external ALU: four 8-bit registers, a program counter
// and a four-state fetch/decode/execute/writeback sequence (one instruction per four cycles).
module controle_ula_aoc (
  input  logic       clock,
  input  logic       reset,
  input  logic       instr_valid,
  input  logic [7:0] instr,
  output logic       instr_ready,
  output logic       ctrlULA,
  output logic [7:0] num2,
  output logic [7:0] num1,
  input  logic [7:0] resultado,
  input  logic       zero,
  output logic [7:0] pc,
  output logic       done,
  input  logic [1:0] dbg_sel,
  output logic [7:0] dbg_dado
);

  typedef enum logic [1:0] {
    OCIOSO     = 2'b00,
    DECODIFICA = 2'b01,
    EXECUTA    = 2'b10,
    ESCREVE    = 2'b11
  } estado_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_BEQ = 2'b10;
  localparam logic [1:0] OP_LDI = 2'b11;

  estado_t    state_r;
  estado_t    state_s;
  logic [7:0] instr_r;
  logic [7:0] res_r;
  logic       zero_r;
  logic       ctrl_r;
  logic [7:0] num2_r;
  logic [7:0] num1_r;
  logic [7:0] pc_r;
  logic [7:0] regs_r [4];
  logic       instr_ready_s;
  logic       done_s;
  logic [1:0] opcode_s;
  logic [1:0] ra_s;
  logic [1:0] rb_s;
  logic [3:0] imm_s;

  // imm overlaps rb; only LDI interprets the low nibble as an immediate
  assign opcode_s = instr_r[7:6];
  assign ra_s     = instr_r[5:4];
  assign rb_s     = instr_r[3:2];
  assign imm_s    = instr_r[3:0];

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= OCIOSO;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      OCIOSO: begin
        if (instr_valid) begin
          state_s = DECODIFICA;
        end else begin
          state_s = OCIOSO;
        end
      end
      DECODIFICA: state_s = EXECUTA;
      EXECUTA:    state_s = ESCREVE;
      ESCREVE:    state_s = OCIOSO;
      default:    state_s = OCIOSO;
    endcase
  end

  // Handshake and retire strobes, both suppressed while reset is asserted
  always_comb begin
    instr_ready_s = 1'b0;
    done_s        = 1'b0;
    case (state_r)
      OCIOSO: begin
        if (reset) begin
          instr_ready_s = 1'b0;
        end else begin
          instr_ready_s = 1'b1;
        end
      end
      ESCREVE: begin
        if (reset) begin
          done_s = 1'b0;
        end else begin
          done_s = 1'b1;
        end
      end
      default: begin
        instr_ready_s = 1'b0;
        done_s        = 1'b0;
      end
    endcase
  end

  // Datapath: instruction latch, ALU operand load, result capture, writeback and pc
  always_ff @(posedge clock) begin
    if (reset) begin
      instr_r <= 8'h00;
      res_r   <= 8'h00;
      zero_r  <= 1'b0;
      ctrl_r  <= 1'b0;
      num2_r  <= 8'h00;
      num1_r  <= 8'h00;
      pc_r    <= 8'h00;
      for (int i = 0; i < 4; i++) begin
        regs_r[i] <= 8'h00;
      end
    end else begin
      case (state_r)
        OCIOSO: begin
          if (instr_valid) begin
            instr_r <= instr;
          end
        end
        DECODIFICA: begin
          case (opcode_s)
            OP_ADD: begin
              num2_r <= regs_r[ra_s];
              num1_r <= regs_r[rb_s];
              ctrl_r <= 1'b0;
            end
            OP_SUB, OP_BEQ: begin
              num2_r <= regs_r[ra_s];
              num1_r <= regs_r[rb_s];
              ctrl_r <= 1'b1;
            end
            OP_LDI: begin
              num2_r <= {4'b0000, imm_s};
              num1_r <= 8'h00;
              ctrl_r <= 1'b0;
            end
            default: begin
              num2_r <= 8'h00;
              num1_r <= 8'h00;
              ctrl_r <= 1'b0;
            end
          endcase
        end
        EXECUTA: begin
          res_r  <= resultado;
          zero_r <= zero;
        end
        ESCREVE: begin
          // The zero flag only steers the branch; arithmetic ops always step by one
          if (opcode_s == OP_BEQ) begin
            if (zero_r) begin
              pc_r <= pc_r + 8'd2;
            end else begin
              pc_r <= pc_r + 8'd1;
            end
          end else begin
            regs_r[ra_s] <= res_r;
            pc_r         <= pc_r + 8'd1;
          end
        end
        default: begin
          instr_r <= instr_r;
        end
      endcase
    end
  end

  assign instr_ready = instr_ready_s;
  assign done        = done_s;
  assign ctrlULA     = ctrl_r;
  assign num2        = num2_r;
  assign num1        = num1_r;
  assign pc          = pc_r;
  assign dbg_dado    = regs_r[dbg_sel];

endmodule

// File: tb/tb_controle_ula_aoc.sv
// Self-checking bench for controle_ula_aoc: behavioural ALU, instruction-level reference
// model, directed scenarios plus randomized instruction streams.
module tb_controle_ula_aoc;

  logic       clock;
  logic       reset;
  logic       instr_valid;
  logic [7:0] instr;
  logic       instr_ready;
  logic       ctrlULA;
  logic [7:0] num2;
  logic [7:0] num1;
  logic [7:0] resultado;
  logic       zero;
  logic [7:0] pc;
  logic       done;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_dado;

  int checks = 0;
  int errors = 0;
  int m_r [4];
  int m_pc;

  controle_ula_aoc dut (
    .clock      (clock),
    .reset      (reset),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_ready(instr_ready),
    .ctrlULA    (ctrlULA),
    .num2       (num2),
    .num1       (num1),
    .resultado  (resultado),
    .zero       (zero),
    .pc         (pc),
    .done       (done),
    .dbg_sel    (dbg_sel),
    .dbg_dado   (dbg_dado)
  );

  // external ALU
  assign resultado = ctrlULA ? (num2 - num1) : (num2 + num1);
  assign zero      = (resultado == 8'h00);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    m_pc = 0;
  endtask

  task automatic model_apply(input logic [7:0] ins);
    int op, ra, rb, imm;
    op = ins[7:6]; ra = ins[5:4]; rb = ins[3:2]; imm = ins[3:0];
    case (op)
      0: begin m_r[ra] = (m_r[ra] + m_r[rb]) % 256;       m_pc = (m_pc + 1) % 256; end
      1: begin m_r[ra] = (m_r[ra] - m_r[rb] + 256) % 256; m_pc = (m_pc + 1) % 256; end
      2: begin m_pc = (m_r[ra] == m_r[rb]) ? (m_pc + 2) % 256 : (m_pc + 1) % 256; end
      default: begin m_r[ra] = imm; m_pc = (m_pc + 1) % 256; end
    endcase
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      checks++;
      if (dbg_dado !== 8'(m_r[i])) begin
        errors++;
        $display("FAIL %s_R%0d got %h exp %h", tag, i, dbg_dado, 8'(m_r[i]));
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    instr_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  // one instruction with full cycle-by-cycle checking
  task automatic run_instr(input logic [7:0] ins);
    int n, op, ra, rb, imm, opc;
    logic [7:0] old_a, e2, e1;
    logic ec;
    @(negedge clock);
    n = 0;
    while (!instr_ready && n < 10) begin @(negedge clock); n++; end
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout got %b exp 1", instr_ready);
      return;
    end
    op = ins[7:6]; ra = ins[5:4]; rb = ins[3:2]; imm = ins[3:0];
    old_a = 8'(m_r[ra]);
    opc   = m_pc;
    if (op == 3) begin e2 = 8'(imm); e1 = 8'h00; ec = 1'b0; end
    else begin e2 = 8'(m_r[ra]); e1 = 8'(m_r[rb]); ec = (op != 0); end
    model_apply(ins);
    dbg_sel = 2'(ra);
    instr = ins;
    instr_valid = 1'b1;
    @(negedge clock);
    instr_valid = 1'b0;
    instr = 8'($urandom);
    checks++;
    if (instr_ready !== 1'b0) begin errors++; $display("FAIL ready_busy got %b exp 0", instr_ready); end
    @(negedge clock);
    checks++;
    if (num2 !== e2) begin errors++; $display("FAIL num2 ins %h got %h exp %h", ins, num2, e2); end
    checks++;
    if (num1 !== e1) begin errors++; $display("FAIL num1 ins %h got %h exp %h", ins, num1, e1); end
    checks++;
    if (ctrlULA !== ec) begin errors++; $display("FAIL ctrl ins %h got %b exp %b", ins, ctrlULA, ec); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_early got %b exp 0", done); end
    @(negedge clock);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL done_c3 ins %h got %b exp 1", ins, done); end
    checks++;
    if (dbg_dado !== old_a) begin errors++; $display("FAIL dbg_pre ins %h got %h exp %h", ins, dbg_dado, old_a); end
    checks++;
    if (pc !== 8'(opc)) begin errors++; $display("FAIL pc_pre ins %h got %h exp %h", ins, pc, 8'(opc)); end
    checks++;
    if (num2 !== e2) begin errors++; $display("FAIL num2_hold ins %h got %h exp %h", ins, num2, e2); end
    @(negedge clock);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_c4 got %b exp 0", done); end
    checks++;
    if (instr_ready !== 1'b1) begin errors++; $display("FAIL ready_c4 got %b exp 1", instr_ready); end
    checks++;
    if (pc !== 8'(m_pc)) begin errors++; $display("FAIL pc ins %h got %h exp %h", ins, pc, 8'(m_pc)); end
    check_regs("wb");
  endtask

  task automatic test_reset();
    reset = 1'b1;
    instr_valid = 1'b1;
    instr = 8'hD5;
    dbg_sel = 2'd0;
    @(negedge clock);
    checks++;
    if (instr_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", instr_ready); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
    @(negedge clock);
    reset = 1'b0;
    instr_valid = 1'b0;
    model_reset();
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin errors++; $display("FAIL rst_drop_ready got %b exp 1", instr_ready); end
    checks++;
    if (pc !== 8'h00) begin errors++; $display("FAIL rst_pc got %h exp 00", pc); end
    checks++;
    if ({ctrlULA, num2, num1} !== 17'h0) begin
      errors++; $display("FAIL rst_alu got %b %h %h exp 0 00 00", ctrlULA, num2, num1);
    end
    check_regs("rst");
  endtask

  task automatic test_ldi();
    run_instr(8'hD5);
    checks++;
    if (pc !== 8'd1 || ctrlULA !== 1'b0) begin
      errors++; $display("FAIL ldi_r1 got pc %h ctrl %b exp pc 01 ctrl 0", pc, ctrlULA);
    end
  endtask

  task automatic test_sub();
    run_instr(8'hE3);
    run_instr(8'h58);
    dbg_sel = 2'd1;
    #1;
    checks++;
    if (dbg_dado !== 8'd2) begin errors++; $display("FAIL sub_r1 got %h exp 02", dbg_dado); end
    run_instr(8'h54);
  endtask

  task automatic test_add_wrap();
    run_instr(8'hF1);
    run_instr(8'hC0);
    run_instr(8'h4C);
    run_instr(8'h0C);
    dbg_sel = 2'd0;
    #1;
    checks++;
    if (dbg_dado !== 8'h00) begin errors++; $display("FAIL add_wrap_r0 got %h exp 00", dbg_dado); end
  endtask

  task automatic run_filler_to(input int target);
    logic [7:0] ins;
    int guard;
    guard = 0;
    while (m_pc != target && guard < 300) begin
      ins = 8'($urandom);
      if (ins[7:6] == 2'b10) ins[7:6] = 2'b11;
      ins[5:4] = ($urandom_range(0, 1) != 0) ? 2'd3 : 2'd0;
      run_instr(ins);
      guard++;
    end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    run_instr(8'hD7);
    run_instr(8'hE7);
    run_filler_to(254);
    run_instr(8'h98);
    checks++;
    if (pc !== 8'h00) begin errors++; $display("FAIL beq_wrap0 got %h exp 00", pc); end
    run_filler_to(253);
    run_instr(8'hE6);
    run_instr(8'h98);
    checks++;
    if (pc !== 8'hFF) begin errors++; $display("FAIL beq_nt got %h exp ff", pc); end
    run_instr(8'h94);
    checks++;
    if (pc !== 8'h01) begin errors++; $display("FAIL beq_wrap1 got %h exp 01", pc); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) run_instr(8'($urandom));
  endtask

  task automatic test_back_to_back();
    logic [7:0] q [6];
    int cyc, idx, ndone, last, extra;
    for (int k = 0; k < 6; k++) q[k] = 8'($urandom);
    cyc = 0; idx = 0; ndone = 0; last = -1; extra = 0;
    @(negedge clock);
    instr = q[0];
    instr_valid = 1'b1;
    while (ndone < 6 && cyc < 100) begin
      if (done) ndone++;
      if (instr_valid && instr_ready) begin
        if (last >= 0) begin
          checks++;
          if (cyc - last != 4) begin errors++; $display("FAIL b2b_gap got %0d exp 4", cyc - last); end
        end
        last = cyc;
        model_apply(q[idx]);
        idx++;
      end
      @(negedge clock);
      cyc++;
      if (idx < 6) instr = q[idx];
      else instr_valid = 1'b0;
    end
    for (int k = 0; k < 8; k++) begin
      if (done) extra++;
      @(negedge clock);
    end
    checks++;
    if (ndone != 6) begin errors++; $display("FAIL b2b_done got %0d exp 6", ndone); end
    checks++;
    if (idx != 6) begin errors++; $display("FAIL b2b_accept got %0d exp 6", idx); end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL b2b_extra_done got %0d exp 0", extra); end
    checks++;
    if (pc !== 8'(m_pc)) begin errors++; $display("FAIL b2b_pc got %h exp %h", pc, 8'(m_pc)); end
    check_regs("b2b");
  endtask

  task automatic test_reset_mid();
    int seen;
    do_reset();
    run_instr(8'hD3);
    @(negedge clock);
    instr = 8'h14;
    instr_valid = 1'b1;
    @(negedge clock);
    instr_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || instr_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_hold got done %b ready %b exp 0 0", done, instr_ready);
    end
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b exp 1", instr_ready); end
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (done) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midrst_done got %0d exp 0", seen); end
    checks++;
    if (pc !== 8'h00) begin errors++; $display("FAIL midrst_pc got %h exp 00", pc); end
    check_regs("midrst");
    // reset landing in the writeback cycle
    instr = 8'hE9;
    instr_valid = 1'b1;
    @(negedge clock);
    instr_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL wbrst_done got %b exp 0", done); end
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (pc !== 8'h00) begin errors++; $display("FAIL wbrst_pc got %h exp 00", pc); end
    check_regs("wbrst");
  endtask

  initial begin
    reset = 1'b1;
    instr_valid = 1'b0;
    instr = 8'h00;
    dbg_sel = 2'd0;
    model_reset();
    test_reset();
    test_ldi();
    test_sub();
    test_add_wrap();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_pc_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
